// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM states, recode operations and iteration count for the radix-4 Booth multiplier
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {ZERO, PM, P2M, MM, M2M} op_e;
  function automatic int booth_iters(input int width);
    return (width + 2) / 2;
  endfunction
endpackage

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: maps a Booth triplet {q1,q0,q_1} to its signed addend selection
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] trip,
  output op_e        op
);
  always_comb
    op = (trip == 3'b000 || trip == 3'b111) ? ZERO :
         (trip == 3'b001 || trip == 3'b010) ? PM   :
         (trip == 3'b011)                   ? P2M  :
         (trip == 3'b100)                   ? M2M  : MM;
endmodule

// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier: sequential radix-4 Booth multiplier, two multiplier bits per cycle, result held until acked
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] product,
  output logic               product_valid,
  input  logic               product_ack
);
  localparam int W2 = WIDTH + 2;
  localparam int N  = booth_iters(WIDTH);
  localparam int CW = $clog2(N + 1);
  state_e          state, state_n;
  op_e             op;
  logic [W2+1:0]   a, m_e, m_2, addend, sum;
  logic [W2-1:0]   q, m;
  logic            q_1;
  logic [CW-1:0]   count;
  logic [2*W2+2:0] cat, sh;
  booth_r4_recoder u_rec (.trip({q[1:0], q_1}), .op(op));
  assign m_e    = {{2{m[W2-1]}}, m};
  assign m_2    = {m[W2-1], m, 1'b0};
  assign addend = op == PM  ? m_e  :
                  op == P2M ? m_2  :
                  op == MM  ? -m_e :
                  op == M2M ? -m_2 : '0;
  assign sum    = a + addend;
  assign cat    = {sum, q, q_1};
  assign sh     = {{2{cat[2*W2+2]}}, cat[2*W2+2:2]};
  always_comb
    state_n = state == IDLE ? (start ? CALC : IDLE) :
              state == CALC ? (count == CW'(1) ? DONE : CALC) :
              (product_ack ? IDLE : DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      m     <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        m     <= signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
        q     <= signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
        a     <= '0;
        q_1   <= 1'b0;
        count <= CW'(N);
      end else if (state == CALC) begin
        {a, q, q_1} <= sh;
        count       <= count - CW'(1);
      end
    end
  assign ready         = state == IDLE;
  assign busy          = state == CALC;
  assign product_valid = state == DONE;
  // the low 2*WIDTH bits of {a,q} are all of q plus the bottom WIDTH-2 bits of a
  assign product       = product_valid ? {a[WIDTH-3:0], q} : '0;
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb_booth_radix4_multiplier: randomized self-checking bench for 8- and 16-bit builds
module tb_booth_radix4_multiplier;
  logic clk = 0, rst_n = 0;
  logic st8 = 0, sm8 = 0, ack8 = 0, rdy8, bsy8, pv8;
  logic [7:0] mc8 = 0, mp8 = 0;
  logic [15:0] prod8;
  logic st16 = 0, sm16 = 0, ack16 = 0, rdy16, bsy16, pv16;
  logic [15:0] mc16 = 0, mp16 = 0;
  logic [31:0] prod16;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  booth_radix4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .signed_mode(sm8), .multiplicand(mc8),
    .multiplier(mp8), .ready(rdy8), .busy(bsy8), .product(prod8),
    .product_valid(pv8), .product_ack(ack8));
  booth_radix4_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .signed_mode(sm16), .multiplicand(mc16),
    .multiplier(mp16), .ready(rdy16), .busy(bsy16), .product(prod16),
    .product_valid(pv16), .product_ack(ack16));
  function automatic logic [31:0] model(input bit s, input logic [15:0] m, input logic [15:0] q, input int w);
    longint x = longint'(m), y = longint'(q), p;
    if (s && m[w-1]) x -= (longint'(1) << w);
    if (s && q[w-1]) y -= (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction
  task automatic do_op8(input bit s, input logic [7:0] m, input logic [7:0] q, input string name);
    logic [15:0] exp = 16'(model(s, {8'h0, m}, {8'h0, q}, 8));
    int cnt = 0;
    @(negedge clk); st8 = 1; sm8 = s; mc8 = m; mp8 = q;
    @(negedge clk); st8 = 0;
    while (!pv8 && cnt < 40) begin @(negedge clk); cnt++; end
    tests++; if (cnt !== 5) begin fails++; $display("FAIL %s latency: got %0d want 5", name, cnt); end
    tests++; if (prod8 !== exp) begin fails++; $display("FAIL %s product: got %h want %h", name, prod8, exp); end
    ack8 = 1; @(negedge clk); ack8 = 0;
    tests++;
    if (pv8 !== 0 || rdy8 !== 1 || prod8 !== 0) begin
      fails++; $display("FAIL %s ack: pv=%b ready=%b product=%h want 0 1 0", name, pv8, rdy8, prod8);
    end
  endtask
  task automatic test_reset;
    rst_n = 0; #1;
    tests++;
    if (rdy8 !== 1 || bsy8 !== 0 || pv8 !== 0 || prod8 !== 0 || rdy16 !== 1 || pv16 !== 0 || prod16 !== 0) begin
      fails++; $display("FAIL reset: ready=%b busy=%b pv=%b prod=%h ready16=%b pv16=%b want 1 0 0 0 1 0", rdy8, bsy8, pv8, prod8, rdy16, pv16);
    end
    repeat (2) @(negedge clk); rst_n = 1;
    @(negedge clk); ack8 = 1; @(negedge clk); ack8 = 0;
    tests++;
    if (rdy8 !== 1 || pv8 !== 0 || bsy8 !== 0) begin
      fails++; $display("FAIL idle_ack: ready=%b pv=%b busy=%b want 1 0 0", rdy8, pv8, bsy8);
    end
  endtask
  task automatic test_basic;
    do_op8(1, 8'd5, 8'd30, "basic_5x30");
  endtask
  task automatic test_corners;
    do_op8(1, 8'h80, 8'h80, "s_m128xm128");
    do_op8(1, 8'h80, 8'h7f, "s_m128x127");
    do_op8(1, 8'hff, 8'hff, "s_m1xm1");
    do_op8(0, 8'hff, 8'hff, "u_255x255");
    do_op8(0, 8'd0, 8'd200, "u_0x200");
    for (int i = 0; i < 20; i++) do_op8(1'($urandom), 8'($urandom), 8'($urandom), "rand8");
  endtask
  task automatic test_ignore_start;
    logic [15:0] exp = 16'(model(1, 16'd100, 16'h00fd, 8));
    int cnt = 0, bad_rdy = 0, bad_hold = 0;
    @(negedge clk); st8 = 1; sm8 = 1; mc8 = 8'd100; mp8 = 8'hfd;
    @(negedge clk);
    while (!pv8 && cnt < 40) begin
      if (rdy8 !== 0) bad_rdy++;
      st8 = 1; sm8 = 1'($urandom); mc8 = 8'($urandom); mp8 = 8'($urandom);
      @(negedge clk); cnt++;
    end
    st8 = 0;
    tests++; if (bad_rdy != 0) begin fails++; $display("FAIL busy_ready: ready high %0d cycles want 0", bad_rdy); end
    tests++; if (cnt !== 5) begin fails++; $display("FAIL busy_latency: got %0d want 5", cnt); end
    tests++; if (prod8 !== exp) begin fails++; $display("FAIL busy_product: got %h want %h", prod8, exp); end
    repeat (10) begin
      @(negedge clk);
      if (prod8 !== exp || pv8 !== 1) bad_hold++;
    end
    tests++; if (bad_hold != 0) begin fails++; $display("FAIL hold: product changed %0d cycles want %h", bad_hold, exp); end
    ack8 = 1; @(negedge clk); ack8 = 0;
    tests++;
    if (rdy8 !== 1 || pv8 !== 0 || prod8 !== 0) begin
      fails++; $display("FAIL hold_ack: ready=%b pv=%b prod=%h want 1 0 0", rdy8, pv8, prod8);
    end
  endtask
  task automatic test_abort;
    int seen = 0;
    @(negedge clk); st8 = 1; sm8 = 0; mc8 = 8'd50; mp8 = 8'd50;
    @(negedge clk); st8 = 0;
    repeat (2) @(negedge clk);
    rst_n = 0; #1;
    tests++;
    if (rdy8 !== 1 || bsy8 !== 0 || pv8 !== 0 || prod8 !== 0) begin
      fails++; $display("FAIL abort: ready=%b busy=%b pv=%b prod=%h want 1 0 0 0", rdy8, bsy8, pv8, prod8);
    end
    @(negedge clk); rst_n = 1;
    repeat (10) begin @(negedge clk); if (pv8 !== 0) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_valid: pv high %0d cycles want 0", seen); end
    do_op8(0, 8'd7, 8'd9, "after_abort");
  endtask
  task automatic test_random16;
    int bad_lat = 0, bad_prod = 0, bad_ack = 0;
    for (int i = 0; i < 2000; i++) begin
      bit s = 1'($urandom);
      logic [15:0] m = 16'($urandom), q = 16'($urandom);
      logic [31:0] exp = model(s, m, q, 16);
      int cnt = 0;
      @(negedge clk); st16 = 1; sm16 = s; mc16 = m; mp16 = q;
      @(negedge clk); st16 = 0; mc16 = 16'($urandom); mp16 = 16'($urandom);
      while (!pv16 && cnt < 40) begin @(negedge clk); cnt++; end
      if (cnt != 9) bad_lat++;
      if (prod16 !== exp) begin
        bad_prod++;
        if (bad_prod <= 5) $display("FAIL rand16 product: s=%b %h*%h got %h want %h", s, m, q, prod16, exp);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if (prod16 !== exp || pv16 !== 1) bad_prod++;
      ack16 = 1; @(negedge clk); ack16 = 0;
      if (rdy16 !== 1 || pv16 !== 0 || prod16 !== 0) bad_ack++;
    end
    tests++; if (bad_lat != 0) begin fails++; $display("FAIL rand16 latency: %0d ops off, want 9 cycles", bad_lat); end
    tests++; if (bad_prod != 0) begin fails++; $display("FAIL rand16 products: %0d wrong, want 0", bad_prod); end
    tests++; if (bad_ack != 0) begin fails++; $display("FAIL rand16 ack: %0d bad, want 0", bad_ack); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_abort();
    test_random16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
